project_switch_ctrl: RTL and testbench

//  Sequences ownership of the shared harness GPIO pins among NUM_PROJ user projects.

---
 rtl/harness_pkg.sv | 26 ++
 rtl/project_switch_ctrl_phase_counter.sv | 38 +++
 rtl/project_switch_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_project_switch_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/harness_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : harness_pkg
//  Description : Shared definitions for the harness GPIO ownership switch:
//                project count, id width, FSM state encoding and the
//                "no owner" reset vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package harness_pkg;

  localparam int NUM_PROJ = 4;
  localparam int ID_W     = 2;

  // Every project held in reset: nobody owns the GPIO pins.
  localparam logic [NUM_PROJ-1:0] c_RST_ALL_ONES = {NUM_PROJ{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISOLATE = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

endpackage : harness_pkg
`default_nettype wire

// File: rtl/project_switch_ctrl_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module      : phase_counter
//  Description : Up-counter with synchronous clear and count enable, plus a
//                terminal-count compare against a runtime-selected limit.
//                One instance times guard, hold and dwell intervals.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_counter
  import harness_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Clear wins over enable so a state entry always starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == i_last);

endmodule : phase_counter
`default_nettype wire

// File: rtl/project_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : project_switch_ctrl
//  Description : Hands ownership of the shared harness GPIO pins from one
//                user project to another. Every switch isolates the outputs,
//                holds all projects in reset, then releases only the target.
//                Optional round-robin rotation after a fixed dwell time.
//  Revision    : 1.0 - initial release
// ============================================================================
module project_switch_ctrl
  import harness_pkg::*;
#(
  parameter int NUM_PROJ     = harness_pkg::NUM_PROJ,
  parameter int ID_W         = harness_pkg::ID_W,
  parameter int GUARD_CYCLES = 2,
  parameter int RST_CYCLES   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int CNT_W        = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel_valid,
  input  logic [ID_W-1:0]     sel_id,
  output logic                sel_ready,
  input  logic                stop,
  input  logic                auto_en,
  output logic [NUM_PROJ-1:0] proj_reset,
  output logic                gpio_oe,
  output logic [ID_W-1:0]     active_id,
  output logic                active_valid,
  output logic                sel_err
);

  localparam logic [NUM_PROJ-1:0] c_ALL_ONES   = {NUM_PROJ{1'b1}};
  localparam logic [CNT_W-1:0]    c_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    c_HOLD_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]    c_DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [ID_W-1:0]     c_LAST_ID    = ID_W'(NUM_PROJ - 1);

  // Registered state and outputs
  state_t              r_state;
  logic                r_stop;
  logic [NUM_PROJ-1:0] r_proj_reset;
  logic                r_gpio_oe;
  logic [ID_W-1:0]     r_active_id;
  logic                r_active_valid;
  logic                r_sel_ready;
  logic                r_sel_err;

  // Next-state / next-output values
  state_t              w_state_nxt;
  logic                w_stop_nxt;
  logic [NUM_PROJ-1:0] w_proj_reset_nxt;
  logic                w_gpio_oe_nxt;
  logic [ID_W-1:0]     w_id_nxt;
  logic                w_active_valid_nxt;
  logic                w_sel_ready_nxt;
  logic                w_sel_err_nxt;

  logic                w_id_bad;
  logic                w_fire;
  logic                w_stop_run;
  logic                w_sel_ok;
  logic [ID_W-1:0]     w_rot_id;
  logic [NUM_PROJ-1:0] w_release_vec;
  logic                w_cnt_clear;
  logic                w_cnt_enable;
  logic [CNT_W-1:0]    w_cnt_last;
  logic                w_tc;

  // Out-of-range ids only exist when the id field can encode more than NUM_PROJ values.
  generate
    if ((1 << ID_W) > NUM_PROJ) begin : g_id_chk
      assign w_id_bad = (sel_id >= ID_W'(NUM_PROJ));
    end else begin : g_id_all_valid
      assign w_id_bad = 1'b0;
    end
  endgenerate

  // A handshake completes whenever ready is high; stop in RUN pre-empts the request entirely.
  assign w_fire     = sel_valid && r_sel_ready;
  assign w_stop_run = (r_state == ST_RUN) && stop;
  assign w_sel_ok   = w_fire && !w_stop_run && !w_id_bad;
  assign w_rot_id   = (r_active_id == c_LAST_ID) ? '0 : r_active_id + 1'b1;

  // Shared interval counter: restarts on every state change.
  assign w_cnt_clear = (w_state_nxt != r_state);

  // Select which interval the counter is timing in the current state.
  always_comb begin
    w_cnt_enable = 1'b0;
    w_cnt_last   = c_DWELL_LAST;
    case (r_state)
      ST_ISOLATE: begin
        w_cnt_enable = 1'b1;
        w_cnt_last   = c_GUARD_LAST;
      end
      ST_HOLD: begin
        w_cnt_enable = 1'b1;
        w_cnt_last   = c_HOLD_LAST;
      end
      ST_RUN: begin
        // Dropping auto_en freezes the dwell count rather than clearing it.
        w_cnt_enable = auto_en;
        w_cnt_last   = c_DWELL_LAST;
      end
      default: begin
        w_cnt_enable = 1'b0;
        w_cnt_last   = c_DWELL_LAST;
      end
    endcase
  end

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (reset),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_enable),
    .i_last   (w_cnt_last),
    .o_tc     (w_tc)
  );

  // Reset vector that releases only the next owner.
  always_comb begin
    w_release_vec = c_ALL_ONES;
    for (int i = 0; i < NUM_PROJ; i++) begin
      w_release_vec[i] = (ID_W'(i) != w_id_nxt);
    end
  end

  // Next-state logic; in RUN the priority is stop > select > auto rotation.
  always_comb begin
    w_state_nxt   = r_state;
    w_stop_nxt    = r_stop;
    w_id_nxt      = r_active_id;
    w_sel_err_nxt = w_fire && !w_stop_run && w_id_bad;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_ok) begin
          w_state_nxt = ST_ISOLATE;
          w_id_nxt    = sel_id;
          w_stop_nxt  = 1'b0;
        end
      end
      ST_ISOLATE: begin
        if (w_tc) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_tc) begin
          if (r_stop) begin
            w_state_nxt = ST_IDLE;
            w_stop_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_ISOLATE;
          w_stop_nxt  = 1'b1;
        end else if (w_sel_ok) begin
          // Re-selecting the current owner still forces a full re-reset.
          w_state_nxt = ST_ISOLATE;
          w_id_nxt    = sel_id;
        end else if (auto_en && w_tc) begin
          w_state_nxt = ST_ISOLATE;
          w_id_nxt    = w_rot_id;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_stop_nxt  = 1'b0;
      end
    endcase
  end

  // Output values are decoded from the state being entered so they register alongside it.
  always_comb begin
    w_proj_reset_nxt   = c_ALL_ONES;
    w_gpio_oe_nxt      = 1'b0;
    w_active_valid_nxt = 1'b0;
    w_sel_ready_nxt    = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_sel_ready_nxt = 1'b1;
      end
      ST_ISOLATE: begin
        // Old owner keeps running with its outputs isolated.
        w_proj_reset_nxt = r_proj_reset;
      end
      ST_HOLD: begin
        w_proj_reset_nxt = c_ALL_ONES;
      end
      ST_RELEASE: begin
        w_proj_reset_nxt = w_release_vec;
      end
      ST_RUN: begin
        w_proj_reset_nxt   = r_proj_reset;
        w_gpio_oe_nxt      = 1'b1;
        w_active_valid_nxt = 1'b1;
        w_sel_ready_nxt    = 1'b1;
      end
      default: begin
        w_proj_reset_nxt = c_ALL_ONES;
      end
    endcase
  end

  // State and output registers; reset returns to IDLE from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_stop         <= 1'b0;
      r_proj_reset   <= c_ALL_ONES;
      r_gpio_oe      <= 1'b0;
      r_active_id    <= '0;
      r_active_valid <= 1'b0;
      r_sel_ready    <= 1'b1;
      r_sel_err      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_stop         <= w_stop_nxt;
      r_proj_reset   <= w_proj_reset_nxt;
      r_gpio_oe      <= w_gpio_oe_nxt;
      r_active_id    <= w_id_nxt;
      r_active_valid <= w_active_valid_nxt;
      r_sel_ready    <= w_sel_ready_nxt;
      r_sel_err      <= w_sel_err_nxt;
    end
  end

  assign proj_reset   = r_proj_reset;
  assign gpio_oe      = r_gpio_oe;
  assign active_id    = r_active_id;
  assign active_valid = r_active_valid;
  assign sel_ready    = r_sel_ready;
  assign sel_err      = r_sel_err;

endmodule : project_switch_ctrl
`default_nettype wire

// File: tb/tb_project_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_project_switch_ctrl
//  Description : Directed self-checking bench for project_switch_ctrl
//                (4 projects, 3-bit id so out-of-range ids can be driven,
//                short dwell for the rotation scenario).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_project_switch_ctrl;

  localparam int NP = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel_valid;
  logic [IW-1:0] sel_id;
  logic          sel_ready;
  logic          stop;
  logic          auto_en;
  logic [NP-1:0] proj_reset;
  logic          gpio_oe;
  logic [IW-1:0] active_id;
  logic          active_valid;
  logic          sel_err;

  int checks = 0;
  int errors = 0;

  project_switch_ctrl #(
    .NUM_PROJ     (NP),
    .ID_W         (IW),
    .GUARD_CYCLES (2),
    .RST_CYCLES   (4),
    .DWELL_CYCLES (10),
    .CNT_W        (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .sel_ready    (sel_ready),
    .stop         (stop),
    .auto_en      (auto_en),
    .proj_reset   (proj_reset),
    .gpio_oe      (gpio_oe),
    .active_id    (active_id),
    .active_valid (active_valid),
    .sel_err      (sel_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sel_valid = 1'b0; sel_id = '0; stop = 1'b0; auto_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (proj_reset !== 4'b1111) begin errors++; $display("FAIL reset_pr got %b exp 1111", proj_reset); end
    checks++; if (gpio_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", gpio_oe); end
    checks++; if (active_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", active_id); end
    checks++; if (active_valid !== 1'b0) begin errors++; $display("FAIL reset_av got %b exp 0", active_valid); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", sel_err); end
    checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", sel_ready); end
  endtask

  // From IDLE select id 2: all ones through k=6, release at k=7, drive at k=8.
  task automatic test_select_from_idle();
    logic [NP-1:0] exp_pr;
    sel_valid = 1'b1; sel_id = 3'd2;
    tick();
    sel_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_pr = (k <= 6) ? 4'b1111 : 4'b1011;
      checks++; if (proj_reset !== exp_pr) begin errors++; $display("FAIL idle_sel_pr k=%0d got %b exp %b", k, proj_reset, exp_pr); end
      checks++; if (gpio_oe !== (k == 8)) begin errors++; $display("FAIL idle_sel_oe k=%0d got %b exp %b", k, gpio_oe, (k == 8)); end
      checks++; if (active_id !== 3'd2) begin errors++; $display("FAIL idle_sel_id k=%0d got %0d exp 2", k, active_id); end
      if (k < 8) tick();
    end
    checks++; if (active_valid !== 1'b1) begin errors++; $display("FAIL idle_sel_av got %b exp 1", active_valid); end
  endtask

  // In RUN owner 2 switch to 0: old owner held 2 cycles, all ones 4, then 1110.
  task automatic test_switch_owner();
    logic [NP-1:0] exp_pr;
    sel_valid = 1'b1; sel_id = 3'd0;
    tick();
    sel_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 2) exp_pr = 4'b1011;
      else if (k <= 6) exp_pr = 4'b1111;
      else exp_pr = 4'b1110;
      checks++; if (proj_reset !== exp_pr) begin errors++; $display("FAIL switch_pr k=%0d got %b exp %b", k, proj_reset, exp_pr); end
      checks++; if (gpio_oe !== (k == 8)) begin errors++; $display("FAIL switch_oe k=%0d got %b exp %b", k, gpio_oe, (k == 8)); end
      checks++; if ($countones(~proj_reset) > 1) begin errors++; $display("FAIL switch_two_owners k=%0d got %b exp at most one 0", k, proj_reset); end
      if (k < 8) tick();
    end
    checks++; if (active_id !== 3'd0) begin errors++; $display("FAIL switch_id got %0d exp 0", active_id); end
  endtask

  // Out-of-range id: one-cycle sel_err, ownership untouched.
  task automatic test_invalid_id();
    sel_valid = 1'b1; sel_id = 3'd5;
    tick();
    sel_valid = 1'b0;
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL bad_id_err got %b exp 1", sel_err); end
    checks++; if (proj_reset !== 4'b1110) begin errors++; $display("FAIL bad_id_pr got %b exp 1110", proj_reset); end
    checks++; if (gpio_oe !== 1'b1) begin errors++; $display("FAIL bad_id_oe got %b exp 1", gpio_oe); end
    checks++; if (active_id !== 3'd0) begin errors++; $display("FAIL bad_id_id got %0d exp 0", active_id); end
    tick();
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL bad_id_pulse got %b exp 0", sel_err); end
    checks++; if ((gpio_oe !== 1'b1) || (active_valid !== 1'b1)) begin errors++; $display("FAIL bad_id_run got oe=%b av=%b exp 1 1", gpio_oe, active_valid); end
  endtask

  // Owner 3 with auto_en: 10 RUN cycles, then wrap to 0 via a full switch.
  task automatic test_auto_rotate();
    logic [NP-1:0] exp_pr;
    sel_valid = 1'b1; sel_id = 3'd3;
    tick();
    sel_valid = 1'b0;
    for (int k = 2; k <= 8; k++) tick();
    checks++; if ((proj_reset !== 4'b0111) || (gpio_oe !== 1'b1)) begin errors++; $display("FAIL auto_start got pr=%b oe=%b exp 0111 1", proj_reset, gpio_oe); end
    auto_en = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      checks++; if (gpio_oe !== 1'b1) begin errors++; $display("FAIL auto_dwell_oe j=%0d got %b exp 1", j, gpio_oe); end
    end
    tick();
    auto_en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 2) exp_pr = 4'b0111;
      else if (k <= 6) exp_pr = 4'b1111;
      else exp_pr = 4'b1110;
      checks++; if (proj_reset !== exp_pr) begin errors++; $display("FAIL auto_rot_pr k=%0d got %b exp %b", k, proj_reset, exp_pr); end
      checks++; if (gpio_oe !== (k == 8)) begin errors++; $display("FAIL auto_rot_oe k=%0d got %b exp %b", k, gpio_oe, (k == 8)); end
      if (k < 8) tick();
    end
    checks++; if (active_id !== 3'd0) begin errors++; $display("FAIL auto_rot_id got %0d exp 0", active_id); end
  endtask

  // stop and sel_valid together in RUN: stop wins, ends in IDLE with all ones.
  task automatic test_stop_priority();
    logic [NP-1:0] exp_pr;
    stop = 1'b1; sel_valid = 1'b1; sel_id = 3'd1;
    tick();
    stop = 1'b0; sel_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_pr = (k <= 2) ? 4'b1110 : 4'b1111;
      checks++; if (proj_reset !== exp_pr) begin errors++; $display("FAIL stop_pr k=%0d got %b exp %b", k, proj_reset, exp_pr); end
      checks++; if ((gpio_oe !== 1'b0) || (sel_err !== 1'b0) || (active_valid !== 1'b0)) begin errors++; $display("FAIL stop_flags k=%0d got oe=%b err=%b av=%b exp 0 0 0", k, gpio_oe, sel_err, active_valid); end
      checks++; if (sel_ready !== (k >= 7)) begin errors++; $display("FAIL stop_rdy k=%0d got %b exp %b", k, sel_ready, (k >= 7)); end
      if (k < 8) tick();
    end
    checks++; if (active_id !== 3'd0) begin errors++; $display("FAIL stop_id got %0d exp 0", active_id); end
  endtask

  // Reset in HOLD returns to IDLE at once; a later select switches normally.
  task automatic test_reset_mid_switch();
    sel_valid = 1'b1; sel_id = 3'd1;
    tick();
    sel_valid = 1'b0;
    for (int k = 2; k <= 4; k++) tick();
    checks++; if ((proj_reset !== 4'b1111) || (sel_ready !== 1'b0)) begin errors++; $display("FAIL hold_pre got pr=%b rdy=%b exp 1111 0", proj_reset, sel_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ((gpio_oe !== 1'b0) || (active_id !== 3'd0) || (proj_reset !== 4'b1111)) begin errors++; $display("FAIL midrst_idle got oe=%b id=%0d pr=%b exp 0 0 1111", gpio_oe, active_id, proj_reset); end
    checks++; if ((sel_ready !== 1'b1) || (active_valid !== 1'b0)) begin errors++; $display("FAIL midrst_rdy got rdy=%b av=%b exp 1 0", sel_ready, active_valid); end
    sel_valid = 1'b1; sel_id = 3'd1;
    tick();
    sel_valid = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      checks++; if (gpio_oe && ($countones(~proj_reset) != 1)) begin errors++; $display("FAIL midrst_inv k=%0d got %b exp one 0 bit", k, proj_reset); end
    end
    checks++; if ((proj_reset !== 4'b1101) || (gpio_oe !== 1'b1) || (active_id !== 3'd1)) begin errors++; $display("FAIL midrst_resel got pr=%b oe=%b id=%0d exp 1101 1 1", proj_reset, gpio_oe, active_id); end
  endtask

  initial begin
    test_reset();
    test_select_from_idle();
    test_switch_owner();
    test_invalid_id();
    test_auto_rotate();
    test_stop_priority();
    test_reset_mid_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_project_switch_ctrl
`default_nettype wire
